// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: merges hazard-unit requests with
// data-memory wait states and the multi-cycle MDU, with a memory timeout watchdog and stall counter.
//
// state    | meaning
// RUN      | normal flow, hazard requests pass through
// MEM_WAIT | M stage waiting on data memory, watchdog running
// MDU_WAIT | E stage waiting on mul/div result, M holds a bubble
// HALT     | memory timed out, pipeline frozen until reset
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF_h,
    input  logic             stallD_h,
    input  logic             FlushD_h,
    input  logic             FlushE_h,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             MduReqE,
    input  logic             MduDoneE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             MduStart,
    output logic             MemErr,
    output logic [CNT_W-1:0] PerfStallCnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  perf_q, perf_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        FlushW     = 1'b0;
        MduStart   = 1'b0;

        case (state_q)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    {StallF, StallD, StallE, StallM} = 4'b1111;
                    FlushW     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_LOAD;
                end else if (MduReqE) begin
                    {StallF, StallD, StallE} = 3'b111;
                    FlushM   = 1'b1;
                    MduStart = 1'b1;
                    state_d  = MDU_WAIT;
                end else begin
                    StallF = stallF_h;
                    StallD = stallD_h;
                    FlushD = FlushD_h;
                    FlushE = FlushE_h;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d = RUN;
                end else begin
                    {StallF, StallD, StallE, StallM} = 4'b1111;
                    FlushW = 1'b1;
                    // Down-counter reaching zero means MEM_TIMEOUT cycles spent here.
                    if (wait_cnt_q == '0) begin
                        state_d   = HALT;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
            end
            MDU_WAIT: begin
                if (MduDoneE) begin
                    state_d = RUN;
                end else begin
                    {StallF, StallD, StallE} = 3'b111;
                    FlushM = 1'b1;
                end
            end
            HALT: begin
                {StallF, StallD, StallE, StallM} = 4'b1111;
            end
            default: state_d = RUN;
        endcase

        if (!reset) begin
            {StallF, StallD, StallE, StallM} = 4'b0000;
            {FlushD, FlushE, FlushM, FlushW} = 4'b0000;
            MduStart = 1'b0;
        end
    end

    assign perf_d = (StallF && (perf_q != {CNT_W{1'b1}})) ? perf_q + 1'b1 : perf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            perf_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            perf_q     <= perf_d;
        end
    end

    assign MemErr       = reset & mem_err_q;
    assign PerfStallCnt = reset ? perf_q : '0;

endmodule
